// File: rtl/dp_seq_pkg.sv
// Shared definitions for the datapath sequencer: instruction field layout, FSM encoding
// and the decoded instruction record.
package dp_seq_pkg;

    localparam int INSTR_W = 10;

    localparam int WE_BIT = 9;
    localparam int OP_HI  = 8;
    localparam int OP_LO  = 6;
    localparam int RD_HI  = 5;
    localparam int RD_LO  = 4;
    localparam int RS1_HI = 3;
    localparam int RS1_LO = 2;
    localparam int RS2_HI = 1;
    localparam int RS2_LO = 0;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        WB   = 2'd2
    } seq_state_e;

    typedef struct packed {
        logic       we;
        logic [2:0] aluop;
        logic [1:0] rd;
        logic [1:0] rs1;
        logic [1:0] rs2;
    } instr_t;

    function automatic instr_t unpack_instr(input logic [INSTR_W-1:0] raw);
        instr_t i;
        i.we    = raw[WE_BIT];
        i.aluop = raw[OP_HI:OP_LO];
        i.rd    = raw[RD_HI:RD_LO];
        i.rs1   = raw[RS1_HI:RS1_LO];
        i.rs2   = raw[RS2_HI:RS2_LO];
        return i;
    endfunction

endpackage

// File: rtl/dp_sequencer_if.sv
// Instruction intake handshake plus the datapath control bus driven by the sequencer.
// master: upstream/datapath environment side; slave: the sequencer.
interface dp_sequencer_if;
    import dp_seq_pkg::*;

    logic               in_valid;
    logic               in_ready;
    logic [INSTR_W-1:0] in_instr;
    logic [2:0]         alucontrol;
    logic [1:0]         addr1;
    logic [1:0]         addr2;
    logic [1:0]         addr3;
    logic               wr;

    modport master (
        output in_valid,
        output in_instr,
        input  in_ready,
        input  alucontrol,
        input  addr1,
        input  addr2,
        input  addr3,
        input  wr
    );

    modport slave (
        input  in_valid,
        input  in_instr,
        output in_ready,
        output alucontrol,
        output addr1,
        output addr2,
        output addr3,
        output wr
    );

endinterface

// File: rtl/seq_fifo.sv
// Synchronous FIFO with occupancy count; DEPTH must be a power of two so pointers
// wrap naturally.
module seq_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 10
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [WIDTH-1:0]         wdata,
    input  logic                     pop,
    output logic [WIDTH-1:0]         rdata,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             do_push;
    logic             do_pop;

    assign full  = (count_q == CW'(DEPTH));
    assign empty = (count_q == '0);
    assign count = count_q;
    assign rdata = mem_q[rd_ptr_q];

    // full/empty come from the registered count, so a pop never frees a slot same-cycle
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            mem_d[wr_ptr_q] = wdata;
            wr_ptr_d        = wr_ptr_q + AW'(1);
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        count_d = count_q + CW'(do_push) - CW'(do_pop);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

endmodule

// File: rtl/dp_sequencer.sv
// Issues buffered micro-instructions to the ALU/register-file datapath as EXEC/WB pairs.
// Optional DP_SEQ_PERF_EN adds a 16-bit retired-instruction counter port.
//
//   state | meaning
//   IDLE  | nothing in flight; pops when FIFO non-empty and not halted
//   EXEC  | operands/aluop driven, wr held low so the result can settle
//   WB    | same drive, wr = we, retire pulse; may pop next for back-to-back issue
module dp_sequencer
    import dp_seq_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    dp_sequencer_if.slave           bus,
    input  logic                    halt,
    output logic                    busy,
    output logic                    retire,
`ifdef DP_SEQ_PERF_EN
    output logic [15:0]             retired_count,
`endif
    output logic [$clog2(DEPTH):0]  fifo_count
);

    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $error("dp_sequencer: DEPTH must be a power of two and at least 2");
    end

    seq_state_e         state_q, state_d;
    instr_t             cur_q, cur_d;
    logic               pop;
    logic [INSTR_W-1:0] fifo_rdata;
    logic               fifo_full;
    logic               fifo_empty;
    logic               push;

    assign push = bus.in_valid && !fifo_full;

    seq_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (INSTR_W)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .wdata (bus.in_instr),
        .pop   (pop),
        .rdata (fifo_rdata),
        .count (fifo_count),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign bus.in_ready = !fifo_full;

    always_comb begin
        state_d = state_q;
        cur_d   = cur_q;
        pop     = 1'b0;
        case (state_q)
            IDLE: begin
                if (!fifo_empty && !halt) begin
                    pop     = 1'b1;
                    cur_d   = unpack_instr(fifo_rdata);
                    state_d = EXEC;
                end
            end
            EXEC: begin
                state_d = WB;
            end
            WB: begin
                if (!fifo_empty && !halt) begin
                    pop     = 1'b1;
                    cur_d   = unpack_instr(fifo_rdata);
                    state_d = EXEC;
                end else begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cur_q   <= '0;
        end else begin
            state_q <= state_d;
            cur_q   <= cur_d;
        end
    end

    // Decoded purely from registered state, so wr can only rise a full cycle after operands
    always_comb begin
        bus.alucontrol = 3'd0;
        bus.addr1      = 2'd0;
        bus.addr2      = 2'd0;
        bus.addr3      = 2'd0;
        bus.wr         = 1'b0;
        busy           = (state_q != IDLE);
        retire         = (state_q == WB);
        if (state_q == EXEC || state_q == WB) begin
            bus.alucontrol = cur_q.aluop;
            bus.addr1      = cur_q.rs1;
            bus.addr2      = cur_q.rs2;
            bus.addr3      = cur_q.rd;
        end
        if (state_q == WB) begin
            bus.wr = cur_q.we;
        end
    end

`ifdef DP_SEQ_PERF_EN
    logic [15:0] retired_count_q, retired_count_d;

    always_comb begin
        retired_count_d = retired_count_q + 16'(retire);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            retired_count_q <= '0;
        end else begin
            retired_count_q <= retired_count_d;
        end
    end

    assign retired_count = retired_count_q;
`endif

endmodule

// File: tb/tb_dp_sequencer.sv
// Directed self-checking bench for dp_sequencer: reset, single issue, full FIFO,
// halt, mid-operation reset and (with DP_SEQ_PERF_EN) counter wrap.
module tb_dp_sequencer;

    logic       clk;
    logic       rst;
    logic       halt;
    logic       busy;
    logic       retire;
    logic [2:0] fifo_count;
`ifdef DP_SEQ_PERF_EN
    logic [15:0] retired_count;
`endif

    dp_sequencer_if bus ();

    dp_sequencer #(.DEPTH(4)) dut (
        .clk           (clk),
        .rst           (rst),
        .bus           (bus),
        .halt          (halt),
        .busy          (busy),
        .retire        (retire),
`ifdef DP_SEQ_PERF_EN
        .retired_count (retired_count),
`endif
        .fifo_count    (fifo_count)
    );

    typedef struct {
        logic [2:0] alu;
        logic [1:0] a1;
        logic [1:0] a2;
        logic [1:0] a3;
        logic       wr;
    } exp_t;

    int           checks = 0;
    int           errors = 0;
    logic [9:0]   push_q [$];
    exp_t         exp_q  [$];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // one cycle of upstream driving from push_q; returns after the edge
    task automatic feed_cycle();
        logic will_push;
        if (push_q.size() > 0) begin
            bus.in_valid = 1'b1;
            bus.in_instr = push_q[0];
        end else begin
            bus.in_valid = 1'b0;
        end
        will_push = bus.in_valid && bus.in_ready;
        tick();
        if (will_push) void'(push_q.pop_front());
        bus.in_valid = 1'b0;
    endtask

    task automatic feed(input int n);
        for (int i = 0; i < n; i++) feed_cycle();
    endtask

    // runs until n retires seen, checking each against exp_q in order
    task automatic drain(input int n, input int budget, input bit chk_gap);
        int   got;
        int   last;
        exp_t e;
        got  = 0;
        last = -1;
        for (int c = 0; c < budget && got < n; c++) begin
            feed_cycle();
            if (retire) begin
                e = exp_q.pop_front();
                chk("ret_alu", 32'(bus.alucontrol), 32'(e.alu));
                chk("ret_addr1", 32'(bus.addr1), 32'(e.a1));
                chk("ret_addr2", 32'(bus.addr2), 32'(e.a2));
                chk("ret_addr3", 32'(bus.addr3), 32'(e.a3));
                chk("ret_wr", 32'(bus.wr), 32'(e.wr));
                if (chk_gap && last >= 0) chk("ret_gap", 32'(c - last), 32'd2);
                last = c;
                got++;
            end else if (busy) begin
                chk("exec_wr_low", 32'(bus.wr), 32'd0);
            end
        end
        chk("drain_count", 32'(got), 32'(n));
    endtask

    initial begin
        bus.in_valid = 1'b0;
        bus.in_instr = '0;
        halt         = 1'b0;
        rst          = 1'b1;

        // 1: reset with in_valid high
        bus.in_valid = 1'b1;
        bus.in_instr = 10'b1_010_11_01_10;
        tick();
        tick();
        chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
        chk("rst_wr", 32'(bus.wr), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_count", 32'(fifo_count), 32'd0);
        chk("rst_retire", 32'(retire), 32'd0);
        chk("rst_alu", 32'(bus.alucontrol), 32'd0);
`ifdef DP_SEQ_PERF_EN
        chk("rst_perf", 32'(retired_count), 32'd0);
`endif
        bus.in_valid = 1'b0;
        rst          = 1'b0;
        tick();
        chk("post_rst_count", 32'(fifo_count), 32'd0);

        // 2: single instruction
        bus.in_valid = 1'b1;
        bus.in_instr = 10'b1_010_11_01_10;
        tick();
        bus.in_valid = 1'b0;
        chk("s_count", 32'(fifo_count), 32'd1);
        chk("s_idle_busy", 32'(busy), 32'd0);
        tick();
        chk("s_exec_busy", 32'(busy), 32'd1);
        chk("s_exec_addr1", 32'(bus.addr1), 32'd1);
        chk("s_exec_addr2", 32'(bus.addr2), 32'd2);
        chk("s_exec_addr3", 32'(bus.addr3), 32'd3);
        chk("s_exec_alu", 32'(bus.alucontrol), 32'd2);
        chk("s_exec_wr", 32'(bus.wr), 32'd0);
        chk("s_exec_retire", 32'(retire), 32'd0);
        tick();
        chk("s_wb_wr", 32'(bus.wr), 32'd1);
        chk("s_wb_retire", 32'(retire), 32'd1);
        chk("s_wb_addr3", 32'(bus.addr3), 32'd3);
        tick();
        chk("s_idle_after", 32'(busy), 32'd0);
        chk("s_idle_wr", 32'(bus.wr), 32'd0);
        chk("s_idle_addr1", 32'(bus.addr1), 32'd0);
        chk("s_idle_retire", 32'(retire), 32'd0);

        // 3: fill to full while halted, fifth held off, then drain back-to-back
        halt = 1'b1;
        push_q = '{10'b1_001_01_10_11, 10'b0_011_10_00_01, 10'b1_100_11_01_00,
                   10'b1_111_00_11_10, 10'b1_101_01_01_01};
        exp_q  = '{'{3'd1, 2'd2, 2'd3, 2'd1, 1'b1},
                   '{3'd3, 2'd0, 2'd1, 2'd2, 1'b0},
                   '{3'd4, 2'd1, 2'd0, 2'd3, 1'b1},
                   '{3'd7, 2'd3, 2'd2, 2'd0, 1'b1},
                   '{3'd5, 2'd1, 2'd1, 2'd1, 1'b1}};
        feed(6);
        chk("full_count", 32'(fifo_count), 32'd4);
        chk("full_in_ready", 32'(bus.in_ready), 32'd0);
        chk("full_halt_busy", 32'(busy), 32'd0);
        halt = 1'b0;
        drain(5, 40, 1'b1);
        tick();
        chk("fill_done_busy", 32'(busy), 32'd0);
        chk("fill_done_count", 32'(fifo_count), 32'd0);

        // 4: halt raised during the first EXEC
        halt = 1'b1;
        push_q = '{10'b1_110_10_01_11, 10'b0_010_01_11_00, 10'b1_001_11_10_10};
        feed(4);
        chk("h_count3", 32'(fifo_count), 32'd3);
        halt = 1'b0;
        tick();
        chk("h_exec_busy", 32'(busy), 32'd1);
        chk("h_exec_alu", 32'(bus.alucontrol), 32'd6);
        chk("h_exec_count", 32'(fifo_count), 32'd2);
        halt = 1'b1;
        tick();
        chk("h_wb_retire", 32'(retire), 32'd1);
        chk("h_wb_wr", 32'(bus.wr), 32'd1);
        chk("h_wb_addr3", 32'(bus.addr3), 32'd2);
        tick();
        chk("h_idle_busy", 32'(busy), 32'd0);
        chk("h_idle_count", 32'(fifo_count), 32'd2);
        tick();
        tick();
        chk("h_hold_busy", 32'(busy), 32'd0);
        chk("h_hold_count", 32'(fifo_count), 32'd2);
        halt = 1'b0;
        exp_q = '{'{3'd2, 2'd3, 2'd0, 2'd1, 1'b0},
                  '{3'd1, 2'd2, 2'd2, 2'd3, 1'b1}};
        drain(2, 20, 1'b1);
        tick();
        chk("h_done_busy", 32'(busy), 32'd0);

        // 5: reset during a writing WB
        push_q = '{10'b1_011_11_11_11, 10'b1_000_00_00_00};
        for (int c = 0; c < 20 && !bus.wr; c++) feed_cycle();
        chk("r_reach_wb_wr", 32'(bus.wr), 32'd1);
        rst = 1'b1;
        tick();
        chk("r_wr", 32'(bus.wr), 32'd0);
        chk("r_count", 32'(fifo_count), 32'd0);
        chk("r_busy", 32'(busy), 32'd0);
        chk("r_retire", 32'(retire), 32'd0);
        chk("r_in_ready", 32'(bus.in_ready), 32'd1);
        rst = 1'b0;
        push_q.delete();
        tick();
        tick();
        chk("r_stays_idle", 32'(busy), 32'd0);

`ifdef DP_SEQ_PERF_EN
        // 6: counter increments and wraps
        chk("p_after_rst", 32'(retired_count), 32'd0);
        push_q = '{10'b1_001_00_01_10};
        exp_q  = '{'{3'd1, 2'd1, 2'd2, 2'd0, 1'b1}};
        drain(1, 10, 1'b0);
        tick();
        chk("p_one", 32'(retired_count), 32'd1);
        force dut.retired_count_q = 16'hFFFF;
        #1;
        release dut.retired_count_q;
        tick();
        chk("p_preset", 32'(retired_count), 32'hFFFF);
        push_q = '{10'b0_100_01_10_11};
        exp_q  = '{'{3'd4, 2'd2, 2'd3, 2'd1, 1'b0}};
        drain(1, 10, 1'b0);
        tick();
        chk("p_wrap", 32'(retired_count), 32'd0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
